// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory, and buffers returned words with their PCs in a small FIFO for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = 3;
  localparam int OW = CW + 1;

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_pc_q, fault_pc_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   word_d [DEPTH];
  logic [31:0]   wpc_q  [DEPTH];
  logic [31:0]   wpc_d  [DEPTH];

  logic          ok;
  logic          not_empty;
  logic          pop;
  logic          push;
  logic          issue;
  logic          raise_fault;
  logic [OW-1:0] occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // 33-bit compare so addresses near 2^32 cannot wrap into the legal range
  assign ok = (pc_q[1:0] == 2'b00) &&
              (({1'b0, pc_q} + 33'd3) < 33'(MEM_BYTES));

  assign not_empty   = (count_q != '0);
  assign instr_valid = not_empty && !redirect_valid;
  assign instr       = not_empty ? word_q[rd_ptr_q] : '0;
  assign instr_pc    = not_empty ? wpc_q[rd_ptr_q]  : '0;
  assign pop         = instr_valid && instr_ready;
  assign push        = inflight_q && !redirect_valid;

  // Credit covers both the FIFO contents and the word still in the memory
  assign occupancy   = OW'(count_q) + OW'(inflight_q) - OW'(pop);
  assign issue       = fetch_en && ok && !fault_q && !redirect_valid &&
                       (occupancy < OW'(DEPTH));
  assign raise_fault = fetch_en && !ok && !fault_q && !redirect_valid;

  assign imem_addr   = pc_q;
  assign imem_we     = 1'b0;
  assign imem_wdata  = 32'h0000_0000;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;
    word_d        = word_q;
    wpc_d         = wpc_q;

    if (issue) begin
      pc_d          = pc_q + 32'd4;
      inflight_pc_d = pc_q;
    end

    if (push) begin
      word_d[wr_ptr_q] = imem_rdata;
      wpc_d[wr_ptr_q]  = inflight_pc_q;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (raise_fault) begin
      fault_d    = 1'b1;
      fault_pc_d = pc_q;
    end

    // Redirect flushes the stream, drops the returning word and clears faults
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fault_d    = 1'b0;
      fault_pc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Payload storage is gated by count/inflight, so it needs no reset
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    word_q        <= word_d;
    wpc_q         <= wpc_d;
  end

endmodule
